// File: rtl/ras_ckpt_if.sv
// Prediction/resolution bus of the return-address stack: prediction-side ops,
// oldest-branch resolution, and the stack/checkpoint status returned.
interface ras_ckpt_if #(
  parameter int unsigned ADDR_WIDTH = 30,
  parameter int unsigned CKPT_NUM   = 8
);
  localparam int unsigned CW = $clog2(CKPT_NUM);

  logic                  stall;
  logic                  pdc_valid;
  logic [2:0]            kind_pdc;
  logic [ADDR_WIDTH-1:0] ret_pc_pdc;
  logic                  ex_valid;
  logic [CW-1:0]         ex_ckpt_id;
  logic                  ex_mis;
  logic [2:0]            kind_ex;
  logic [ADDR_WIDTH-1:0] ret_pc_ex;

  logic [ADDR_WIDTH-1:0] ras_top;
  logic                  ras_valid;
  logic                  pdc_ack;
  logic [CW-1:0]         ckpt_id;
  logic                  ckpt_full;
  logic                  ckpt_err;
  logic [31:0]           recover_cnt;

  modport master (
    output stall, pdc_valid, kind_pdc, ret_pc_pdc,
    output ex_valid, ex_ckpt_id, ex_mis, kind_ex, ret_pc_ex,
    input  ras_top, ras_valid, pdc_ack, ckpt_id, ckpt_full, ckpt_err, recover_cnt
  );

  modport slave (
    input  stall, pdc_valid, kind_pdc, ret_pc_pdc,
    input  ex_valid, ex_ckpt_id, ex_mis, kind_ex, ret_pc_ex,
    output ras_top, ras_valid, pdc_ack, ckpt_id, ckpt_full, ckpt_err, recover_cnt
  );
endinterface

// File: rtl/ras_ckpt.sv
// Circular return-address stack with in-order lightweight checkpoints ({tp, cnt, top})
// so a mispredicted branch can repair the stack and re-apply its real kind.
module ras_ckpt #(
  parameter int unsigned ADDR_WIDTH = 30,
  parameter int unsigned STACK_LEN  = 16,
  parameter int unsigned CKPT_NUM   = 8
) (
  input logic       clk,
  input logic       rst,
  ras_ckpt_if.slave bus
);
  localparam int unsigned SW = $clog2(STACK_LEN);
  localparam int unsigned CW = $clog2(CKPT_NUM);

  localparam logic [2:0] KindNone = 3'd0;
  localparam logic [2:0] KindRet  = 3'd4;
  localparam logic [2:0] KindCall = 3'd6;

  typedef logic [SW-1:0]         tp_t;
  typedef logic [SW:0]           cnt_t;
  typedef logic [CW-1:0]         tag_t;
  typedef logic [CW:0]           occ_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;

  localparam cnt_t CntMax = cnt_t'(STACK_LEN);
  localparam occ_t OccMax = occ_t'(CKPT_NUM);

  tp_t         r_tp;
  cnt_t        r_cnt;
  addr_t       r_stack [STACK_LEN];
  tag_t        r_head;
  tag_t        r_tail;
  occ_t        r_occ;
  logic        r_err;
  logic [31:0] r_rcv;

  tp_t         r_ck_tp  [CKPT_NUM];
  cnt_t        r_ck_cnt [CKPT_NUM];
  addr_t       r_ck_top [CKPT_NUM];

  logic        w_full;
  logic        w_ex_mis;
  logic        w_ack;
  logic        w_tag_ok;
  logic        w_release;
  logic        w_recover;
  logic        w_tag_bad;
  logic        w_stack_op;
  logic        w_push;
  tp_t         w_base_tp;
  cnt_t        w_base_cnt;
  logic [2:0]  w_kind;
  addr_t       w_ret_pc;
  tp_t         w_tp_nxt;
  cnt_t        w_cnt_nxt;

  assign w_full     = (r_occ == OccMax);
  assign w_ex_mis   = bus.ex_valid & bus.ex_mis;
  // Any mispredict, even one with a bad tag, squashes the prediction side this cycle.
  assign w_ack      = ~rst & bus.pdc_valid & ~bus.stall & ~w_full &
                      (bus.kind_pdc != KindNone) & ~w_ex_mis;
  assign w_tag_ok   = (r_occ != '0) && (bus.ex_ckpt_id == r_head);
  assign w_release  = bus.ex_valid & ~bus.ex_mis & w_tag_ok;
  assign w_recover  = w_ex_mis & w_tag_ok;
  assign w_tag_bad  = bus.ex_valid & ~w_tag_ok;
  assign w_stack_op = w_recover | w_ack;

  // Recovery and an accepted prediction are mutually exclusive, so one adder path serves both.
  always_comb begin
    w_base_tp  = w_recover ? r_ck_tp[r_head]  : r_tp;
    w_base_cnt = w_recover ? r_ck_cnt[r_head] : r_cnt;
    w_kind     = w_recover ? bus.kind_ex      : bus.kind_pdc;
    w_ret_pc   = w_recover ? bus.ret_pc_ex    : bus.ret_pc_pdc;
    w_tp_nxt   = w_base_tp;
    w_cnt_nxt  = w_base_cnt;
    w_push     = 1'b0;
    if (w_stack_op) begin
      case (w_kind)
        KindCall: begin
          w_tp_nxt  = w_base_tp + 1'b1;
          w_cnt_nxt = (w_base_cnt == CntMax) ? w_base_cnt : w_base_cnt + 1'b1;
          w_push    = 1'b1;
        end
        KindRet: begin
          if (w_base_cnt != '0) begin
            w_tp_nxt  = w_base_tp - 1'b1;
            w_cnt_nxt = w_base_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tp   <= '0;
      r_cnt  <= '0;
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
      r_err  <= 1'b0;
      r_rcv  <= '0;
      for (int unsigned i = 0; i < STACK_LEN; i++) begin
        r_stack[i] <= '0;
      end
    end else begin
      if (w_stack_op) begin
        r_tp  <= w_tp_nxt;
        r_cnt <= w_cnt_nxt;
      end
      if (w_recover) begin
        r_stack[w_base_tp] <= r_ck_top[r_head];
      end
      if (w_push) begin
        r_stack[w_tp_nxt] <= w_ret_pc;
      end
      if (w_ack) begin
        r_tail <= r_tail + 1'b1;
      end
      if (w_recover) begin
        r_head <= r_tail;
        r_occ  <= '0;
        r_rcv  <= r_rcv + 32'd1;
      end else begin
        r_head <= r_head + tag_t'(w_release);
        r_occ  <= r_occ + occ_t'(w_ack) - occ_t'(w_release);
      end
      if (w_tag_bad) begin
        r_err <= 1'b1;
      end
    end
  end

  // Checkpoint payload is only meaningful while its slot is occupied, so it is not reset.
  always_ff @(posedge clk) begin
    if (w_ack) begin
      r_ck_tp[r_tail]  <= r_tp;
      r_ck_cnt[r_tail] <= r_cnt;
      r_ck_top[r_tail] <= r_stack[r_tp];
    end
  end

  assign bus.ras_top     = r_stack[r_tp];
  assign bus.ras_valid   = (r_cnt != '0);
  assign bus.pdc_ack     = w_ack;
  assign bus.ckpt_id     = r_tail;
  assign bus.ckpt_full   = w_full;
  assign bus.ckpt_err    = r_err;
  assign bus.recover_cnt = r_rcv;
endmodule

// File: tb/tb_ras_ckpt.sv
// Directed and random checks of ras_ckpt against a queue-based reference model
// (STACK_LEN=4, CKPT_NUM=4).
module tb_ras_ckpt;
  localparam int unsigned AW = 30;
  localparam int unsigned SL = 4;
  localparam int unsigned CN = 4;
  localparam int unsigned CW = 2;

  localparam logic [2:0] KNone = 3'd0;
  localparam logic [2:0] KDir  = 3'd1;
  localparam logic [2:0] KRet  = 3'd4;
  localparam logic [2:0] KInd  = 3'd5;
  localparam logic [2:0] KCall = 3'd6;
  localparam logic [2:0] KJmp  = 3'd7;

  logic clk;
  logic rst;

  ras_ckpt_if #(.ADDR_WIDTH(AW), .CKPT_NUM(CN)) bus ();

  ras_ckpt #(.ADDR_WIDTH(AW), .STACK_LEN(SL), .CKPT_NUM(CN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int            tag;
    int            tp;
    int            cnt;
    logic [AW-1:0] top;
  } ck_t;

  ck_t           q[$];
  logic [AW-1:0] m_stk [SL];
  int            m_tp;
  int            m_cnt;
  int            m_tail;
  logic          m_err;
  logic [31:0]   m_rcv;
  int            n_tests;
  int            n_fail;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int head_tag();
    if (q.size() != 0) return q[0].tag;
    return m_tail;
  endfunction

  function automatic logic [2:0] pick_kind(input int r);
    case (r)
      0:       return KNone;
      1:       return KDir;
      2:       return KRet;
      3:       return KInd;
      4:       return KCall;
      5:       return KJmp;
      6:       return KRet;
      default: return KCall;
    endcase
  endfunction

  task automatic m_apply(input logic [2:0] k, input logic [AW-1:0] pc);
    if (k == KCall) begin
      m_tp = (m_tp + 1) % SL;
      m_stk[m_tp] = pc;
      if (m_cnt < SL) m_cnt++;
    end else if (k == KRet && m_cnt > 0) begin
      m_tp = (m_tp + SL - 1) % SL;
      m_cnt--;
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_tp = 0;
    m_cnt = 0;
    m_tail = 0;
    m_err = 1'b0;
    m_rcv = '0;
    for (int i = 0; i < SL; i++) m_stk[i] = '0;
  endtask

  task automatic set_in(input logic pv, input logic [2:0] k, input logic [AW-1:0] pc,
                        input logic ev, input int tag, input logic mis,
                        input logic [2:0] kx, input logic [AW-1:0] pcx, input logic st);
    bus.pdc_valid  = pv;
    bus.kind_pdc   = k;
    bus.ret_pc_pdc = pc;
    bus.ex_valid   = ev;
    bus.ex_ckpt_id = tag[CW-1:0];
    bus.ex_mis     = mis;
    bus.kind_ex    = kx;
    bus.ret_pc_ex  = pcx;
    bus.stall      = st;
  endtask

  task automatic idle();
    set_in(1'b0, KNone, '0, 1'b0, 0, 1'b0, KNone, '0, 1'b0);
  endtask

  task automatic check_regs();
    chk("ras_valid", 64'(bus.ras_valid), 64'(m_cnt != 0));
    chk("ckpt_err", 64'(bus.ckpt_err), 64'(m_err));
    chk("recover_cnt", 64'(bus.recover_cnt), 64'(m_rcv));
    chk("ckpt_full_reg", 64'(bus.ckpt_full), 64'(q.size() == CN));
    if (m_cnt != 0) chk("ras_top", 64'(bus.ras_top), 64'(m_stk[m_tp]));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ras_top"}, 64'(bus.ras_top), 64'd0);
    chk({tag, "_ras_valid"}, 64'(bus.ras_valid), 64'd0);
    chk({tag, "_pdc_ack"}, 64'(bus.pdc_ack), 64'd0);
    chk({tag, "_ckpt_id"}, 64'(bus.ckpt_id), 64'd0);
    chk({tag, "_ckpt_full"}, 64'(bus.ckpt_full), 64'd0);
    chk({tag, "_ckpt_err"}, 64'(bus.ckpt_err), 64'd0);
    chk({tag, "_recover_cnt"}, 64'(bus.recover_cnt), 64'd0);
  endtask

  // Called just after a rising edge with inputs applied; returns just after the next edge.
  task automatic step();
    logic full;
    logic ack;
    logic tagok;
    ck_t  c;
    #1;
    full  = (q.size() == CN);
    ack   = bus.pdc_valid && !bus.stall && !full && (bus.kind_pdc != KNone) &&
            !(bus.ex_valid && bus.ex_mis);
    tagok = (q.size() != 0) && (int'(bus.ex_ckpt_id) == q[0].tag);
    chk("pdc_ack", 64'(bus.pdc_ack), 64'(ack));
    chk("ckpt_full", 64'(bus.ckpt_full), 64'(full));
    if (ack) chk("ckpt_id", 64'(bus.ckpt_id), 64'(m_tail));
    if (bus.ex_valid && !tagok) m_err = 1'b1;
    if (ack) begin
      c.tag = m_tail;
      c.tp  = m_tp;
      c.cnt = m_cnt;
      c.top = m_stk[m_tp];
      q.push_back(c);
      m_tail = (m_tail + 1) % CN;
      m_apply(bus.kind_pdc, bus.ret_pc_pdc);
    end
    if (bus.ex_valid && tagok) begin
      if (!bus.ex_mis) begin
        void'(q.pop_front());
      end else begin
        c = q[0];
        m_tp = c.tp;
        m_cnt = c.cnt;
        m_stk[m_tp] = c.top;
        m_apply(bus.kind_ex, bus.ret_pc_ex);
        q.delete();
        m_rcv++;
      end
    end
    @(posedge clk);
    #1;
    check_regs();
    idle();
  endtask

  task automatic drive(input logic pv, input logic [2:0] k, input logic [AW-1:0] pc,
                       input logic ev, input int tag, input logic mis,
                       input logic [2:0] kx, input logic [AW-1:0] pcx, input logic st);
    set_in(pv, k, pc, ev, tag, mis, kx, pcx, st);
    step();
  endtask

  task automatic pred(input logic [2:0] k, input logic [AW-1:0] pc);
    drive(1'b1, k, pc, 1'b0, 0, 1'b0, KNone, '0, 1'b0);
  endtask

  task automatic rel(input int tag);
    drive(1'b0, KNone, '0, 1'b1, tag, 1'b0, KNone, '0, 1'b0);
  endtask

  task automatic mispredict(input int tag, input logic [2:0] kx, input logic [AW-1:0] pcx);
    drive(1'b0, KNone, '0, 1'b1, tag, 1'b1, kx, pcx, 1'b0);
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    model_reset();
    #1;
    check_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic          pv;
    logic          ev;
    logic          mis;
    logic          st;
    logic [2:0]    k;
    logic [2:0]    kx;
    logic [AW-1:0] pc;
    logic [AW-1:0] pcx;
    int            tag;

    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    idle();
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Five CALLs overflow a 4-deep stack; four RETs then drain it.
    for (int i = 0; i < 5; i++) begin
      pred(KCall, AW'(16 * (i + 1)));
      rel(head_tag());
    end
    chk("req037_top", 64'(bus.ras_top), 64'h50);
    chk("req037_cnt", 64'(dut.r_cnt), 64'd4);
    pred(KRet, '0);
    chk("req037_ret1", 64'(bus.ras_top), 64'h40);
    drive(1'b1, KRet, '0, 1'b1, head_tag(), 1'b0, KNone, '0, 1'b0);
    chk("req037_ret2", 64'(bus.ras_top), 64'h30);
    drive(1'b1, KRet, '0, 1'b1, head_tag(), 1'b0, KNone, '0, 1'b0);
    chk("req037_ret3", 64'(bus.ras_top), 64'h20);
    drive(1'b1, KRet, '0, 1'b1, head_tag(), 1'b0, KNone, '0, 1'b0);
    chk("req037_empty", 64'(bus.ras_valid), 64'd0);
    rel(head_tag());

    // Checkpoint exhaustion and release.
    for (int i = 0; i < 4; i++) pred(KDir, '0);
    chk("req038_full", 64'(bus.ckpt_full), 64'd1);
    set_in(1'b1, KJmp, '0, 1'b0, 0, 1'b0, KNone, '0, 1'b0);
    #1;
    chk("req038_fifth_ack", 64'(bus.pdc_ack), 64'd0);
    step();
    set_in(1'b0, KNone, '0, 1'b1, head_tag(), 1'b0, KNone, '0, 1'b0);
    #1;
    chk("req038_full_at_release", 64'(bus.ckpt_full), 64'd1);
    step();
    chk("req038_full_after", 64'(bus.ckpt_full), 64'd0);
    for (int i = 0; i < 3; i++) rel(head_tag());

    // Mispredict of the oldest branch re-applies its real CALL.
    do_reset();
    pred(KCall, AW'(32'h10));
    pred(KRet, '0);
    mispredict(0, KCall, AW'(32'h10));
    chk("req039_top", 64'(bus.ras_top), 64'h10);
    chk("req039_cnt", 64'(dut.r_cnt), 64'd1);
    chk("req039_rcv", 64'(bus.recover_cnt), 64'd1);
    chk("req039_occ", 64'(dut.r_occ), 64'd0);

    // A CALL presented alongside a mispredict is dropped.
    pred(KDir, '0);
    set_in(1'b1, KCall, AW'(32'h99), 1'b1, head_tag(), 1'b1, KNone, '0, 1'b0);
    #1;
    chk("req040_ack", 64'(bus.pdc_ack), 64'd0);
    step();
    chk("req040_top", 64'(bus.ras_top), 64'h10);
    chk("req040_rcv", 64'(bus.recover_cnt), 64'd2);
    pred(KRet, '0);
    chk("req040_cnt", 64'(dut.r_cnt), 64'd0);
    rel(head_tag());

    // Stall blocks prediction but not release.
    pred(KCall, AW'(32'h33));
    drive(1'b1, KCall, AW'(32'h44), 1'b1, head_tag(), 1'b0, KNone, '0, 1'b1);
    chk("stall_top", 64'(bus.ras_top), 64'h33);

    // Wrong tag is ignored and flagged.
    do_reset();
    pred(KCall, AW'(32'hAA));
    drive(1'b0, KNone, '0, 1'b1, 2, 1'b1, KCall, AW'(32'h55), 1'b0);
    chk("req041_err", 64'(bus.ckpt_err), 64'd1);
    chk("req041_top", 64'(bus.ras_top), 64'hAA);
    chk("req041_tp", 64'(dut.r_tp), 64'd1);
    chk("req041_cnt", 64'(dut.r_cnt), 64'd1);
    chk("req041_rcv", 64'(bus.recover_cnt), 64'd0);
    rel(0);

    // Reset overrides an in-progress recovery.
    pred(KCall, AW'(32'h66));
    set_in(1'b0, KNone, '0, 1'b1, head_tag(), 1'b1, KCall, AW'(32'h77), 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_zero("req042_async");
    @(posedge clk);
    #1;
    idle();
    check_zero("req042_edge");
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check_zero("req042_after");

    // Random traffic against the model.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      pv  = ($urandom_range(0, 1) == 1);
      k   = pick_kind(int'($urandom_range(0, 7)));
      pc  = AW'($urandom);
      ev  = ($urandom_range(0, 2) == 0);
      tag = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 3)) : head_tag();
      mis = ($urandom_range(0, 5) == 0);
      kx  = pick_kind(int'($urandom_range(0, 7)));
      pcx = AW'($urandom);
      st  = ($urandom_range(0, 7) == 0);
      drive(pv, k, pc, ev, tag, mis, kx, pcx, st);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
